sram_arbiter: RTL and testbench

//  Shares the single external SRAM between the CPU port and the read-only video fetch port.

---
 rtl/sram_arbiter_if.sv | 44 ++++
 rtl/sram_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the CPU/video request ports, the arbiter and the SRAM controller.
// The arbiter uses the slave view; requesters plus the controller data path use the master view.
interface sram_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [17:0] cpu_address;
    logic [15:0] cpu_data_write;
    logic        cpu_ack;
    logic [15:0] cpu_data_read;
    logic        cpu_read_valid;

    logic        vid_req;
    logic [17:0] vid_address;
    logic        vid_ack;
    logic [15:0] vid_data_read;
    logic        vid_read_valid;

    logic        sram_we;
    logic [17:0] sram_address;
    logic [15:0] sram_data_write;
    logic [15:0] sram_data_read;

    logic        busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_address, cpu_data_write,
        input  vid_req, vid_address,
        input  sram_data_read,
        output cpu_ack, cpu_data_read, cpu_read_valid,
        output vid_ack, vid_data_read, vid_read_valid,
        output sram_we, sram_address, sram_data_write,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_address, cpu_data_write,
        output vid_req, vid_address,
        output sram_data_read,
        input  cpu_ack, cpu_data_read, cpu_read_valid,
        input  vid_ack, vid_data_read, vid_read_valid,
        input  sram_we, sram_address, sram_data_write,
        input  busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one external SRAM between the CPU port and the read-only video fetch port.
// Video wins ties unless the CPU has been passed over STARVE_LIMIT times in a row.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int WRITE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          sram_we_q, sram_we_d;
    logic [17:0]   sram_addr_q, sram_addr_d;
    logic [15:0]   sram_wdata_q, sram_wdata_d;
    logic [1:0]    pipe_v_q, pipe_v_d;
    logic [1:0]    pipe_vid_q, pipe_vid_d;
    logic          cpu_rv_q, cpu_rv_d;
    logic          vid_rv_q, vid_rv_d;
    logic [15:0]   cpu_rd_q, cpu_rd_d;
    logic [15:0]   vid_rd_q, vid_rd_d;

    logic window;
    logic cpu_starved;
    logic vid_grant;
    logic cpu_grant;

    // Accepts are only possible while the bus is free for a new command next cycle.
    assign window      = !rst && (state_q == IDLE || state_q == READ || state_q == RECOVER);
    assign cpu_starved = (starve_q == SW'(STARVE_LIMIT));
    assign vid_grant   = window && bus.vid_req && !(bus.cpu_req && cpu_starved);
    assign cpu_grant   = window && bus.cpu_req && !vid_grant;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        wcnt_d       = wcnt_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        pipe_v_d     = {pipe_v_q[0], 1'b0};
        pipe_vid_d   = {pipe_vid_q[0], 1'b0};
        cpu_rv_d     = pipe_v_q[1] && !pipe_vid_q[1];
        vid_rv_d     = pipe_v_q[1] && pipe_vid_q[1];
        cpu_rd_d     = cpu_rv_d ? bus.sram_data_read : cpu_rd_q;
        vid_rd_d     = vid_rv_d ? bus.sram_data_read : vid_rd_q;

        if (!bus.cpu_req || cpu_grant) begin
            starve_d = '0;
        end else if (vid_grant && !cpu_starved) begin
            starve_d = starve_q + SW'(1);
        end

        case (state_q)
            IDLE, READ, RECOVER: begin
                if (cpu_grant || vid_grant) begin
                    sram_addr_d = cpu_grant ? bus.cpu_address : bus.vid_address;
                    if (cpu_grant && bus.cpu_we) begin
                        state_d      = WRITE;
                        sram_we_d    = 1'b1;
                        sram_wdata_d = bus.cpu_data_write;
                        wcnt_d       = WW'(WRITE_CYCLES - 1);
                    end else begin
                        state_d       = READ;
                        sram_we_d     = 1'b0;
                        pipe_v_d[0]   = 1'b1;
                        pipe_vid_d[0] = vid_grant;
                    end
                end else begin
                    state_d   = IDLE;
                    sram_we_d = 1'b0;
                end
            end
            WRITE: begin
                if (wcnt_q == '0) begin
                    state_d   = RECOVER;
                    sram_we_d = 1'b0;
                end else begin
                    wcnt_d = wcnt_q - WW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                sram_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            wcnt_q       <= '0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            pipe_v_q     <= '0;
            pipe_vid_q   <= '0;
            cpu_rv_q     <= 1'b0;
            vid_rv_q     <= 1'b0;
            cpu_rd_q     <= '0;
            vid_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            wcnt_q       <= wcnt_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            pipe_v_q     <= pipe_v_d;
            pipe_vid_q   <= pipe_vid_d;
            cpu_rv_q     <= cpu_rv_d;
            vid_rv_q     <= vid_rv_d;
            cpu_rd_q     <= cpu_rd_d;
            vid_rd_q     <= vid_rd_d;
        end
    end

    assign bus.cpu_ack         = cpu_grant;
    assign bus.vid_ack         = vid_grant;
    assign bus.cpu_read_valid  = cpu_rv_q;
    assign bus.vid_read_valid  = vid_rv_q;
    assign bus.cpu_data_read   = cpu_rd_q;
    assign bus.vid_data_read   = vid_rd_q;
    assign bus.sram_we         = sram_we_q;
    assign bus.sram_address    = sram_addr_q;
    assign bus.sram_data_write = sram_wdata_q;
    assign bus.busy            = (state_q != IDLE) || (|pipe_v_q);
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a per-cycle vector table for single transfers, plus
// hand-written sequences for streaming reads, starvation, and reset mid-operation.
module tb_sram_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sram_arbiter_if bus ();

    sram_arbiter #(.STARVE_LIMIT(3), .WRITE_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [logic [17:0]];

    function automatic logic [15:0] mem_rd(logic [17:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Controller model: registered read of the presented address every edge, write when WE is high.
    always @(posedge clk) begin : sram_model
        logic [15:0] rdata;
        rdata = mem_rd(bus.sram_address);
        if (bus.sram_we) mem[bus.sram_address] = bus.sram_data_write;
        bus.sram_data_read <= rdata;
    end

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [17:0] cpu_addr;
        logic [15:0] cpu_wdata;
        logic        vid_req;
        logic [17:0] vid_addr;
        logic        exp_cpu_ack;
        logic        exp_vid_ack;
        logic        exp_we;
        logic [17:0] exp_addr;
        logic [15:0] exp_wdata;
        logic        exp_crv;
        logic [15:0] exp_crd;
        logic        exp_vrv;
        logic [15:0] exp_vrd;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(logic creq, logic cwe, logic [17:0] caddr, logic [15:0] cwd,
                                logic vreq, logic [17:0] vaddr,
                                logic eca, logic eva, logic ewe, logic [17:0] eaddr,
                                logic [15:0] ewd, logic ecrv, logic [15:0] ecrd,
                                logic evrv, logic [15:0] evrd, logic ebusy);
        vec_t v;
        v.cpu_req = creq;  v.cpu_we = cwe;  v.cpu_addr = caddr;  v.cpu_wdata = cwd;
        v.vid_req = vreq;  v.vid_addr = vaddr;
        v.exp_cpu_ack = eca;  v.exp_vid_ack = eva;  v.exp_we = ewe;  v.exp_addr = eaddr;
        v.exp_wdata = ewd;  v.exp_crv = ecrv;  v.exp_crd = ecrd;  v.exp_vrv = evrv;
        v.exp_vrd = evrd;  v.exp_busy = ebusy;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.cpu_req        = v.cpu_req;
        bus.cpu_we         = v.cpu_we;
        bus.cpu_address    = v.cpu_addr;
        bus.cpu_data_write = v.cpu_wdata;
        bus.vid_req        = v.vid_req;
        bus.vid_address    = v.vid_addr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.cpu_req        = 1'b0;
        bus.cpu_we         = 1'b0;
        bus.cpu_address    = '0;
        bus.cpu_data_write = '0;
        bus.vid_req        = 1'b0;
        bus.vid_address    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " cpu_ack"},         bus.cpu_ack, 0);
        checkOutput({tag, " vid_ack"},         bus.vid_ack, 0);
        checkOutput({tag, " cpu_read_valid"},  bus.cpu_read_valid, 0);
        checkOutput({tag, " vid_read_valid"},  bus.vid_read_valid, 0);
        checkOutput({tag, " cpu_data_read"},   bus.cpu_data_read, 0);
        checkOutput({tag, " vid_data_read"},   bus.vid_data_read, 0);
        checkOutput({tag, " sram_we"},         bus.sram_we, 0);
        checkOutput({tag, " sram_address"},    bus.sram_address, 0);
        checkOutput({tag, " sram_data_write"}, bus.sram_data_write, 0);
        checkOutput({tag, " busy"},            bus.busy, 0);
    endtask

    task automatic cpu_read(input string tag, input logic [17:0] addr, input logic [15:0] exp);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = addr;
        #1 checkOutput({tag, " ack"}, bus.cpu_ack, 1);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1 checkOutput({tag, " sram_address"}, bus.sram_address, 32'(addr));
        @(negedge clk);
        @(negedge clk);
        #1 checkOutput({tag, " read_valid"}, bus.cpu_read_valid, 1);
        checkOutput({tag, " data"}, bus.cpu_data_read, 32'(exp));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mem[18'h00010] = 16'hBEEF;
        mem[18'h00200] = 16'h0C0D;
        for (int i = 0; i < 8; i++) mem[18'h00100 + 18'(i)] = 16'h7000 + 16'(i);

        //            creq cwe caddr     cwd       vreq vaddr     cack vack we  addr      wd        crv crd       vrv vrd       busy
        vecs[0]  = mk(1, 0, 18'h00010, 16'h0000, 0, 18'h00000, 1, 0, 0, 18'h00000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        vecs[1]  = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h00010, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1);
        vecs[2]  = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h00010, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1);
        vecs[3]  = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h00010, 16'h0000, 1, 16'hBEEF, 0, 16'h0000, 0);
        vecs[4]  = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h00010, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, 0);
        vecs[5]  = mk(1, 1, 18'h3FFFF, 16'h1234, 0, 18'h00000, 1, 0, 0, 18'h00010, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, 0);
        vecs[6]  = mk(1, 0, 18'h3FFFF, 16'h0000, 0, 18'h00000, 0, 0, 1, 18'h3FFFF, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 1);
        vecs[7]  = mk(1, 0, 18'h3FFFF, 16'h0000, 0, 18'h00000, 1, 0, 0, 18'h3FFFF, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 1);
        vecs[8]  = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h3FFFF, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 1);
        vecs[9]  = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h3FFFF, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 1);
        vecs[10] = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h3FFFF, 16'h1234, 1, 16'h1234, 0, 16'h0000, 0);
        vecs[11] = mk(1, 1, 18'h00020, 16'hA5A5, 0, 18'h00000, 1, 0, 0, 18'h3FFFF, 16'h1234, 0, 16'h1234, 0, 16'h0000, 0);
        vecs[12] = mk(0, 0, 18'h00000, 16'h0000, 1, 18'h00020, 0, 0, 1, 18'h00020, 16'hA5A5, 0, 16'h1234, 0, 16'h0000, 1);
        vecs[13] = mk(0, 0, 18'h00000, 16'h0000, 1, 18'h00020, 0, 1, 0, 18'h00020, 16'hA5A5, 0, 16'h1234, 0, 16'h0000, 1);
        vecs[14] = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h00020, 16'hA5A5, 0, 16'h1234, 0, 16'h0000, 1);
        vecs[15] = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h00020, 16'hA5A5, 0, 16'h1234, 0, 16'h0000, 1);
        vecs[16] = mk(0, 0, 18'h00000, 16'h0000, 0, 18'h00000, 0, 0, 0, 18'h00020, 16'hA5A5, 0, 16'h1234, 1, 16'hA5A5, 0);

        // Requests held during reset must not be acknowledged.
        drive_idle();
        bus.cpu_req = 1'b1;
        bus.vid_req = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        #1 check_all_zero("post_reset");

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d cpu_ack", i),         bus.cpu_ack,         32'(vecs[i].exp_cpu_ack));
            checkOutput($sformatf("v%0d vid_ack", i),         bus.vid_ack,         32'(vecs[i].exp_vid_ack));
            checkOutput($sformatf("v%0d sram_we", i),         bus.sram_we,         32'(vecs[i].exp_we));
            checkOutput($sformatf("v%0d sram_address", i),    bus.sram_address,    32'(vecs[i].exp_addr));
            checkOutput($sformatf("v%0d sram_data_write", i), bus.sram_data_write, 32'(vecs[i].exp_wdata));
            checkOutput($sformatf("v%0d cpu_read_valid", i),  bus.cpu_read_valid,  32'(vecs[i].exp_crv));
            checkOutput($sformatf("v%0d cpu_data_read", i),   bus.cpu_data_read,   32'(vecs[i].exp_crd));
            checkOutput($sformatf("v%0d vid_read_valid", i),  bus.vid_read_valid,  32'(vecs[i].exp_vrv));
            checkOutput($sformatf("v%0d vid_data_read", i),   bus.vid_data_read,   32'(vecs[i].exp_vrd));
            checkOutput($sformatf("v%0d busy", i),            bus.busy,            32'(vecs[i].exp_busy));
        end

        @(negedge clk);
        drive_idle();

        // Streaming video reads: one accept per cycle, completions three cycles later in order.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.vid_req     = (c < 8);
            bus.vid_address = 18'h00100 + 18'(c);
            #1;
            checkOutput($sformatf("stream c%0d vid_ack", c), bus.vid_ack, 32'(c < 8));
            checkOutput($sformatf("stream c%0d cpu_ack", c), bus.cpu_ack, 0);
            if (c >= 1 && c <= 8)
                checkOutput($sformatf("stream c%0d sram_address", c), bus.sram_address, 32'h100 + 32'(c - 1));
            checkOutput($sformatf("stream c%0d vid_read_valid", c), bus.vid_read_valid, 32'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10)
                checkOutput($sformatf("stream c%0d vid_data_read", c), bus.vid_data_read, 32'h7000 + 32'(c - 3));
        end
        drive_idle();
        @(negedge clk);

        // Both ports requesting continuously: the CPU is forced through after three video grants.
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            bus.cpu_req     = (c < 8);
            bus.cpu_we      = 1'b0;
            bus.cpu_address = 18'h00010;
            bus.vid_req     = (c < 8);
            bus.vid_address = 18'h00200;
            #1;
            checkOutput($sformatf("starve c%0d cpu_ack", c), bus.cpu_ack, 32'(c == 3 || c == 7));
            checkOutput($sformatf("starve c%0d vid_ack", c), bus.vid_ack, 32'(c < 8 && c != 3 && c != 7));
            checkOutput($sformatf("starve c%0d cpu_read_valid", c), bus.cpu_read_valid, 32'(c == 6 || c == 10));
            checkOutput($sformatf("starve c%0d vid_read_valid", c), bus.vid_read_valid,
                        32'(c >= 3 && c <= 9 && c != 6));
            if (c == 6 || c == 10)
                checkOutput($sformatf("starve c%0d cpu_data_read", c), bus.cpu_data_read, 32'hBEEF);
            if (c >= 3 && c <= 9 && c != 6)
                checkOutput($sformatf("starve c%0d vid_data_read", c), bus.vid_data_read, 32'h0C0D);
        end
        drive_idle();
        @(negedge clk);

        // Reset with two reads in flight: their completions must never appear.
        @(negedge clk);
        bus.vid_req = 1'b1; bus.vid_address = 18'h00101;
        #1 checkOutput("inflight vid_ack", bus.vid_ack, 1);
        @(negedge clk);
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 18'h00010;
        #1 checkOutput("inflight cpu_ack", bus.cpu_ack, 1);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1 checkOutput("inflight busy", bus.busy, 1);
        rst = 1'b1;
        #1 check_all_zero("inflight rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("after_rst c%0d cpu_read_valid", c), bus.cpu_read_valid, 0);
            checkOutput($sformatf("after_rst c%0d vid_read_valid", c), bus.vid_read_valid, 0);
            checkOutput($sformatf("after_rst c%0d busy", c), bus.busy, 0);
        end

        // Reset during a write: WE drops at once and the write never lands.
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_address = 18'h00030; bus.cpu_data_write = 16'h5555;
        #1 checkOutput("wr_rst accept", bus.cpu_ack, 1);
        @(negedge clk);
        #1;
        checkOutput("wr_rst sram_we before", bus.sram_we, 1);
        checkOutput("wr_rst no ack in WRITE", bus.cpu_ack, 0);
        rst = 1'b1;
        #1 check_all_zero("wr_rst");
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        #1;
        checkOutput("wr_rst idle busy", bus.busy, 0);
        checkOutput("wr_rst idle sram_we", bus.sram_we, 0);
        @(negedge clk);
        #1;
        checkOutput("wr_rst no replay ack", bus.cpu_ack, 0);
        checkOutput("wr_rst still idle", bus.busy, 0);
        cpu_read("abandoned readback", 18'h00030, 16'h0000);
        cpu_read("a5a5 readback", 18'h00020, 16'hA5A5);
        cpu_read("top addr readback", 18'h3FFFF, 16'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
